mac_vec_engine: RTL and testbench

- Parametrised successor to the single-mode FIFO-to-FIFO MAC in the face-search datapath.
- Pops paired signed fixed-point elements from two host-to-FPGA FIFOs and reduces each VEC_LEN-element vector to one scalar.
- Two run-time modes: dot product (a·b) or squared Euclidean distance Σ(a−b)².
- Each result is saturated to 32 bits and pushed to the FPGA-to-host FIFO.

---
 rtl/mac_vec_pkg.sv | 18 +
 rtl/mac_vec_pe.sv | 71 +++++++
 rtl/mac_vec_engine.sv | 158 +++++++++++++++
 tb/tb_mac_vec_engine.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_vec_pkg.sv
// Shared types and constants for the vector MAC engine: FSM encoding, mode
// selectors and the 32-bit saturation limits applied to each result.
package mac_vec_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    localparam logic MODE_DOT = 1'b0;
    localparam logic MODE_L2  = 1'b1;

    localparam logic [31:0] SAT_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] SAT_MIN = 32'h8000_0000;

endpackage

// File: rtl/mac_vec_pe.sv
// Per-element datapath: operand register, then either a*b or (a-b)^2 into the
// product register. first/last tags ride alongside the valid bit.
module mac_vec_pe #(
    parameter int DATA_W = 16,
    parameter int PROD_W = 2 * DATA_W + 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    input  logic                     mode,
    input  logic                     valid,
    input  logic                     first_in,
    input  logic                     last_in,
    output logic signed [PROD_W-1:0] prod,
    output logic                     prod_valid,
    output logic                     first,
    output logic                     last
);
    import mac_vec_pkg::*;

    localparam int DIFF_W = DATA_W + 1;

    logic signed [DATA_W-1:0] r_a;
    logic signed [DATA_W-1:0] r_b;
    logic [1:0]               r_vld_pipe;
    logic [1:0]               r_first_pipe;
    logic [1:0]               r_last_pipe;
    logic signed [PROD_W-1:0] r_prod;

    logic signed [DIFF_W-1:0] w_diff;
    logic signed [PROD_W-1:0] w_de;
    logic signed [PROD_W-1:0] w_ae;
    logic signed [PROD_W-1:0] w_be;
    logic signed [PROD_W-1:0] w_prod;

    // Operands widened before the multiply so the product is computed at full width
    assign w_diff = DIFF_W'(r_a) - DIFF_W'(r_b);
    assign w_de   = PROD_W'(w_diff);
    assign w_ae   = PROD_W'(r_a);
    assign w_be   = PROD_W'(r_b);
    assign w_prod = (mode == MODE_L2) ? (w_de * w_de) : (w_ae * w_be);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a          <= '0;
            r_b          <= '0;
            r_vld_pipe   <= '0;
            r_first_pipe <= '0;
            r_last_pipe  <= '0;
            r_prod       <= '0;
        end else begin
            r_vld_pipe   <= {r_vld_pipe[0], valid};
            r_first_pipe <= {r_first_pipe[0], first_in};
            r_last_pipe  <= {r_last_pipe[0], last_in};
            if (valid) begin
                r_a <= a;
                r_b <= b;
            end
            if (r_vld_pipe[0]) begin
                r_prod <= w_prod;
            end
        end
    end

    assign prod       = r_prod;
    assign prod_valid = r_vld_pipe[1];
    assign first      = r_first_pipe[1];
    assign last       = r_last_pipe[1];

endmodule

// File: rtl/mac_vec_engine.sv
// FIFO-to-FIFO vector reducer: pops paired elements, accumulates dot product or
// squared L2 distance over VEC_LEN elements, writes a saturated 32-bit result.
module mac_vec_engine #(
    parameter int DATA_W  = 16,
    parameter int VEC_LEN = 128,
    parameter int ACC_W   = 48,
    parameter int CNT_W   = 16
) (
    input  logic             bus_clk,
    input  logic             rst,
    input  logic             mode,
    input  logic             fifo_host_to_fpga_empty_1st,
    output logic             fifo_host_to_fpga_rden_1st,
    input  logic [31:0]      fifo_host_to_fpga_dout_1st,
    input  logic             fifo_host_to_fpga_empty_2nd,
    output logic             fifo_host_to_fpga_rden_2nd,
    input  logic [31:0]      fifo_host_to_fpga_dout_2nd,
    input  logic             fifo_fpga_to_host_full,
    output logic             fifo_fpga_to_host_wren,
    output logic [31:0]      fifo_fpga_to_host_din,
    output logic             sat_o,
    output logic             busy,
    output logic [CNT_W-1:0] vec_done_cnt
);
    import mac_vec_pkg::*;

    localparam int PROD_W = 2 * DATA_W + 2;
    localparam int IW     = $clog2(VEC_LEN + 1);

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [IW-1:0]            r_issued;
    logic                     r_mode;
    logic                     r_rd_vld;
    logic                     r_rd_first;
    logic                     r_rd_last;
    logic signed [ACC_W-1:0]  r_acc;
    logic [CNT_W-1:0]         r_cnt;

    logic                     w_avail;
    logic                     w_last_rd;
    logic                     w_rd;
    logic                     w_wr;
    logic signed [PROD_W-1:0] w_prod;
    logic                     w_pvld;
    logic                     w_pfirst;
    logic                     w_plast;
    logic signed [ACC_W-1:0]  w_pext;
    logic [ACC_W-32:0]        w_hi;
    logic                     w_ovf_pos;
    logic                     w_ovf_neg;
    logic                     w_unused_hi;

    assign w_avail     = !fifo_host_to_fpga_empty_1st && !fifo_host_to_fpga_empty_2nd;
    assign w_last_rd   = (r_issued == IW'(VEC_LEN - 1));
    assign w_unused_hi = ^{fifo_host_to_fpga_dout_1st[31:DATA_W], fifo_host_to_fpga_dout_2nd[31:DATA_W]};

    always_comb begin
        w_state_nxt = r_state;
        w_rd        = 1'b0;
        w_wr        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_avail) begin
                    w_rd        = 1'b1;
                    w_state_nxt = (VEC_LEN == 1) ? ST_DRAIN : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (w_avail && (r_issued < IW'(VEC_LEN))) begin
                    w_rd = 1'b1;
                    if (w_last_rd) begin
                        w_state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (w_pvld && w_plast) begin
                    w_state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                w_wr = !fifo_fpga_to_host_full;
                if (!fifo_fpga_to_host_full) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge bus_clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_issued   <= '0;
            r_mode     <= MODE_DOT;
            r_rd_vld   <= 1'b0;
            r_rd_first <= 1'b0;
            r_rd_last  <= 1'b0;
            r_acc      <= '0;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rd_vld   <= w_rd;
            r_rd_first <= w_rd && (r_state == ST_IDLE);
            // In IDLE the counter is stale from the previous vector; the first read is last only for VEC_LEN==1
            r_rd_last  <= w_rd && ((r_state == ST_IDLE) ? (VEC_LEN == 1) : w_last_rd);
            if (w_rd) begin
                if (r_state == ST_IDLE) begin
                    r_issued <= IW'(1);
                    r_mode   <= mode;
                end else begin
                    r_issued <= r_issued + IW'(1);
                end
            end
            if (w_pvld) begin
                r_acc <= w_pfirst ? w_pext : (r_acc + w_pext);
            end
            if (w_wr) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    mac_vec_pe #(
        .DATA_W (DATA_W),
        .PROD_W (PROD_W)
    ) u_pe (
        .clk        (bus_clk),
        .rst        (rst),
        .a          (fifo_host_to_fpga_dout_1st[DATA_W-1:0]),
        .b          (fifo_host_to_fpga_dout_2nd[DATA_W-1:0]),
        .mode       (r_mode),
        .valid      (r_rd_vld),
        .first_in   (r_rd_first),
        .last_in    (r_rd_last),
        .prod       (w_prod),
        .prod_valid (w_pvld),
        .first      (w_pfirst),
        .last       (w_plast)
    );

    assign w_pext = ACC_W'(w_prod);

    // Bits 31 and up must all equal the sign for the value to fit in 32 bits
    assign w_hi      = r_acc[ACC_W-1:31];
    assign w_ovf_pos = !r_acc[ACC_W-1] && (|w_hi);
    assign w_ovf_neg = r_acc[ACC_W-1] && !(&w_hi);

    assign fifo_host_to_fpga_rden_1st = w_rd && !rst;
    assign fifo_host_to_fpga_rden_2nd = w_rd && !rst;
    assign fifo_fpga_to_host_wren     = w_wr;
    assign fifo_fpga_to_host_din      = w_ovf_pos ? SAT_MAX : (w_ovf_neg ? SAT_MIN : r_acc[31:0]);
    assign sat_o                      = (r_state == ST_WRITE) && (w_ovf_pos || w_ovf_neg);
    assign busy                       = (r_state != ST_IDLE);
    assign vec_done_cnt               = r_cnt;

endmodule

// File: tb/tb_mac_vec_engine.sv
// Scoreboard bench for mac_vec_engine with VEC_LEN=4 and a 3-bit done counter
// so wrap-around is reachable; FIFOs are modelled as arrays with read pointers.
module tb_mac_vec_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode;
    logic        e1, e2, r1, r2, full, wren, sat, busy;
    logic [31:0] d1, d2, din;
    logic [2:0]  cnt;

    logic [31:0] memA [0:255];
    logic [31:0] memB [0:255];
    int          wr_p = 0;
    int          rd_a = 0;
    int          rd_b = 0;
    logic        hold_a = 1'b0;
    logic        hold_b = 1'b0;

    typedef struct {
        logic [31:0] din;
        logic        sat;
    } exp_t;
    exp_t sb [$];

    int         n_vec = 0;
    int         n_bad = 0;
    int         n_res = 0;
    int         cyc = 0;
    int         last_rd = 0;
    logic [2:0] exp_cnt = 3'd0;
    logic       full_seen = 1'b0;

    always #5 clk = ~clk;

    assign e1 = (wr_p == rd_a) || hold_a;
    assign e2 = (wr_p == rd_b) || hold_b;

    mac_vec_engine #(
        .DATA_W  (16),
        .VEC_LEN (4),
        .ACC_W   (48),
        .CNT_W   (3)
    ) dut (
        .bus_clk                     (clk),
        .rst                         (rst),
        .mode                        (mode),
        .fifo_host_to_fpga_empty_1st (e1),
        .fifo_host_to_fpga_rden_1st  (r1),
        .fifo_host_to_fpga_dout_1st  (d1),
        .fifo_host_to_fpga_empty_2nd (e2),
        .fifo_host_to_fpga_rden_2nd  (r2),
        .fifo_host_to_fpga_dout_2nd  (d2),
        .fifo_fpga_to_host_full      (full),
        .fifo_fpga_to_host_wren      (wren),
        .fifo_fpga_to_host_din       (din),
        .sat_o                       (sat),
        .busy                        (busy),
        .vec_done_cnt                (cnt)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (r1) begin
            d1   <= memA[rd_a[7:0]];
            rd_a <= rd_a + 1;
        end
        if (r2) begin
            d2   <= memB[rd_b[7:0]];
            rd_b <= rd_b + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: protocol checks every cycle, result compare on each wren
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            exp_cnt   = 3'd0;
            full_seen = 1'b0;
        end else begin
            if (r1 !== r2) begin
                n_bad++;
                $display("FAIL rden_pair at cycle %0d: rden_1st=%b rden_2nd=%b", cyc, r1, r2);
            end
            if ((r1 || r2) && (e1 || e2)) begin
                n_bad++;
                $display("FAIL rden_while_empty at cycle %0d: empty=%b%b", cyc, e1, e2);
            end
            if (full) full_seen = 1'b1;
            if (r1) last_rd = cyc;
            if (wren) begin
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_wren: din=%0h with empty scoreboard", din);
                end else begin
                    e = sb.pop_front();
                    chk("din", din, e.din);
                    chk("sat_o", {31'b0, sat}, {31'b0, e.sat});
                    chk("vec_done_cnt_at_wren", {29'b0, cnt}, {29'b0, exp_cnt});
                    if (!full_seen) chk("rden_to_wren_latency", cyc - last_rd, 32'd4);
                end
                exp_cnt   = exp_cnt + 3'd1;
                full_seen = 1'b0;
                n_res++;
            end
        end
    end

    task automatic push(input logic [15:0] a, input logic [15:0] b);
        memA[wr_p[7:0]] = {16'hDEAD, a};
        memB[wr_p[7:0]] = {16'hBEEF, b};
        wr_p++;
    endtask

    // av/bv hold four 16-bit elements, first element in the top chunk
    task automatic vec(input logic [63:0] av, input logic [63:0] bv,
                       input logic [31:0] ed, input logic es, input bit expect_res);
        exp_t e;
        if (expect_res) begin
            e.din = ed;
            e.sat = es;
            sb.push_back(e);
        end
        for (int i = 3; i >= 0; i--) push(av[i*16 +: 16], bv[i*16 +: 16]);
    endtask

    task automatic wait_res(input int n);
        int k = 0;
        while (n_res < n && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        n_vec++;
        if (n_res < n) begin
            n_bad++;
            $display("FAIL wait_result_timeout: got %0d results, expected %0d", n_res, n);
        end
    endtask

    task automatic wait_rd(input int n);
        int k = 0;
        while (rd_a < n && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        n_vec++;
        if (rd_a < n) begin
            n_bad++;
            $display("FAIL wait_read_timeout: got %0d reads, expected %0d", rd_a, n);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rden"}, {30'b0, r1, r2}, 32'd0);
        chk({tag, "_wren"}, {31'b0, wren}, 32'd0);
        chk({tag, "_din"}, din, 32'd0);
        chk({tag, "_sat"}, {31'b0, sat}, 32'd0);
        chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
        chk({tag, "_cnt"}, {29'b0, cnt}, 32'd0);
    endtask

    localparam logic [63:0] V1234 = 64'h0001_0002_0003_0004;
    localparam logic [63:0] V5678 = 64'h0005_0006_0007_0008;

    initial begin
        int base;
        rst  = 1'b1;
        mode = 1'b0;
        full = 1'b0;
        #1;
        chk_reset_outputs("reset");
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // Dot product 1*5+2*6+3*7+4*8
        mode = 1'b0;
        vec(V1234, V5678, 32'd70, 1'b0, 1'b1);
        wait_res(1);
        @(negedge clk) chk("cnt_after_first", {29'b0, cnt}, 32'd1);
        @(posedge clk); #1;

        // L2: 9+4+1+0, then (-3-2)^2 with a mode flip after the first read
        mode = 1'b1;
        vec(V1234, 64'h0004_0004_0004_0004, 32'd14, 1'b0, 1'b1);
        wait_res(2);
        base = rd_a;
        vec(64'hFFFD_0000_0000_0000, 64'h0002_0000_0000_0000, 32'd25, 1'b0, 1'b1);
        wait_rd(base + 1);
        mode = 1'b0;
        wait_res(3);

        // Empty flags toggling on offset phases
        hold_a = 1'b1;
        hold_b = 1'b1;
        vec(V1234, V5678, 32'd70, 1'b0, 1'b1);
        for (int k = 0; k < 120 && n_res < 4; k++) begin
            int kk;
            @(posedge clk); #1;
            kk     = k + 1;
            hold_a = k[1];
            hold_b = kk[1];
        end
        hold_a = 1'b0;
        hold_b = 1'b0;
        wait_res(4);

        // Result FIFO full across WRITE entry; the second vector must wait
        full = 1'b1;
        base = rd_a;
        vec(V1234, V5678, 32'd70, 1'b0, 1'b1);
        vec(V5678, V1234, 32'd70, 1'b0, 1'b1);
        wait_rd(base + 4);
        repeat (3) @(posedge clk);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("full_wren", {31'b0, wren}, 32'd0);
            chk("full_din_held", din, 32'd70);
            chk("full_no_rden", {30'b0, r1, r2}, 32'd0);
        end
        @(posedge clk); #1;
        full = 1'b0;
        wait_res(6);

        // Saturation in both directions; the 8th result wraps the 3-bit counter
        vec(64'h7FFF_7FFF_7FFF_7FFF, 64'h7FFF_7FFF_7FFF_7FFF, 32'h7FFF_FFFF, 1'b1, 1'b1);
        vec(64'h8000_8000_8000_8000, 64'h7FFF_7FFF_7FFF_7FFF, 32'h8000_0000, 1'b1, 1'b1);
        wait_res(8);
        @(negedge clk) chk("cnt_wrap", {29'b0, cnt}, 32'd0);
        @(posedge clk); #1;

        // Reset in the middle of a vector
        base = rd_a;
        vec(64'h0064_0064_0064_0064, 64'h0064_0064_0064_0064, 32'd0, 1'b0, 1'b0);
        wait_rd(base + 2);
        #2 rst = 1'b1;
        #1;
        chk_reset_outputs("midvec_reset");
        wr_p = rd_a;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        vec(V1234, V5678, 32'd70, 1'b0, 1'b1);
        wait_res(9);
        @(negedge clk) chk("cnt_after_reset", {29'b0, cnt}, 32'd1);
        chk("scoreboard_drained", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
